// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, TX engine states and the oversampling factor.
package uart_pkg;

  localparam int OVERSAMPLE = 8;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } uart_tx_state_t;

  function automatic logic parity_enabled(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD: return 1'b1;
      PAR_NONE:          return 1'b0;
      default:           return 1'b0;  // reserved code behaves as no parity
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/level flags.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + LVL_ONE;
    else if (w_pop && !w_push)
      w_level_nxt = r_level - LVL_ONE;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_gen2.sv
// UART transmitter: AXI-Stream input FIFO feeding a frame engine with per-frame
// latched parity / stop-bit / bit-period configuration and back-to-back framing.
module uart_tx_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [15:0]                   prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done
);

  import uart_pkg::*;

  localparam int CNT_W = 19;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic                  w_fifo_wr;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_launch;

  uart_tx_state_t        r_state;
  uart_tx_state_t        w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      r_reload;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_bit_idx_nxt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_two_stop;
  logic                  r_txd;
  logic                  w_txd_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;

  logic [15:0]           w_prescale_eff;
  logic [CNT_W-1:0]      w_reload;
  logic                  w_bit_end;

  assign w_fifo_wr = s_axis_tvalid && s_axis_tready;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (s_axis_tdata),
    .i_rd_en   (w_launch),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (fifo_level)
  );

  // Reload value for one bit period; a prescale of 0 is treated as 1.
  assign w_prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_reload       = CNT_W'(w_prescale_eff) * CNT_W'(OVERSAMPLE) - CNT_ONE;
  assign w_bit_end      = (r_cnt == '0);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = w_bit_end ? r_reload : r_cnt - CNT_ONE;
    w_shift_nxt      = r_shift;
    w_bit_idx_nxt    = r_bit_idx;
    w_txd_nxt        = r_txd;
    w_frame_done_nxt = 1'b0;
    w_launch         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = r_cnt;
        w_txd_nxt = 1'b1;
        w_launch  = !w_fifo_empty;
      end
      ST_START: if (w_bit_end) begin
        w_state_nxt   = ST_DATA;
        w_txd_nxt     = r_shift[0];
        w_shift_nxt   = r_shift >> 1;
        w_bit_idx_nxt = '0;
      end
      ST_DATA: if (w_bit_end) begin
        if (r_bit_idx == LAST_IDX) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP1;
          w_txd_nxt   = r_par_en ? r_par_bit : 1'b1;
        end else begin
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + IDX_ONE;
        end
      end
      ST_PARITY: if (w_bit_end) begin
        w_state_nxt = ST_STOP1;
        w_txd_nxt   = 1'b1;
      end
      ST_STOP1: if (w_bit_end) begin
        if (r_two_stop) begin
          w_state_nxt = ST_STOP2;
        end else begin
          w_state_nxt      = ST_IDLE;
          w_frame_done_nxt = 1'b1;
          w_launch         = !w_fifo_empty;
        end
      end
      ST_STOP2: if (w_bit_end) begin
        w_state_nxt      = ST_IDLE;
        w_frame_done_nxt = 1'b1;
        w_launch         = !w_fifo_empty;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Starting a frame overrides the end-of-frame return to IDLE, giving zero idle gap.
    if (w_launch) begin
      w_state_nxt = ST_START;
      w_txd_nxt   = 1'b0;
      w_cnt_nxt   = w_reload;
      w_shift_nxt = w_fifo_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_txd        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_txd        <= w_txd_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Line configuration is captured only when a frame is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload   <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_launch) begin
      r_reload   <= w_reload;
      r_par_en   <= parity_enabled(parity_mode);
      r_par_bit  <= (^w_fifo_data) ^ (parity_mode == PAR_ODD);
      r_two_stop <= two_stop;
    end
  end

  assign s_axis_tready = !w_fifo_full;
  assign txd           = r_txd;
  assign frame_done    = r_frame_done;
  assign busy          = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Scoreboard bench for uart_tx_gen2: stimulus queues expected frames, a line monitor
// checks every txd sample and the frame_done pulse against a bit-list reference model.
`timescale 1ns/1ps
module tb_uart_tx_gen2;

  localparam int DW    = 8;
  localparam int FD    = 4;
  localparam int LVL_W = $clog2(FD) + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    int         period;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DW-1:0]    s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [15:0]      prescale = 16'd1;
  logic [1:0]       parity_mode = 2'b00;
  logic             two_stop = 1'b0;
  logic             txd;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic             frame_done;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  frame_t sb_q[$];
  int     starts[$];
  int     n_done_seen = 0;
  int     exp_done = 0;
  int     spurious = 0;
  int     last_acc_cyc = 0;

  uart_tx_gen2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .txd           (txd),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required earlier end", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, then one or two 1s.
  function automatic int frame_bits(input frame_t f, output logic [15:0] bits);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    n       = 1;
    for (int i = 0; i < 8; i++) begin
      bits[n] = f.data[i];
      n++;
    end
    if (f.mode == 2'b01) begin
      bits[n] = ^f.data;
      n++;
    end else if (f.mode == 2'b10) begin
      bits[n] = ~^f.data;
      n++;
    end
    n += f.two ? 2 : 1;
    return n;
  endfunction

  logic        mon_in_frame = 1'b0;
  logic        mon_done_due = 1'b0;
  int          mon_idx = 0;
  int          mon_len = 0;
  int          mon_mism = 0;
  logic [15:0] mon_bits = '1;
  frame_t      mon_cur;

  task automatic mon_sample();
    if (txd !== mon_bits[mon_idx / mon_cur.period]) mon_mism++;
    mon_idx++;
    if (mon_idx == mon_len) begin
      mon_in_frame = 1'b0;
      mon_done_due = 1'b1;
      check($sformatf("frame_0x%02h_bit_mismatches", mon_cur.data), mon_mism, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in_frame = 1'b0;
      mon_done_due = 1'b0;
    end else begin
      if (mon_done_due) begin
        check("frame_done_pulse", frame_done, 1'b1);
        if (frame_done) n_done_seen++;
        mon_done_due = 1'b0;
      end else if (frame_done) begin
        spurious++;
      end
      if (mon_in_frame) begin
        mon_sample();
      end else if (txd === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_start_bit_queue_size", sb_q.size(), 1);
        end else begin
          mon_cur      = sb_q.pop_front();
          mon_len      = frame_bits(mon_cur, mon_bits) * mon_cur.period;
          mon_idx      = 0;
          mon_mism     = 0;
          mon_in_frame = 1'b1;
          starts.push_back(cyc);
          mon_sample();
        end
      end
    end
  end

  task automatic set_cfg(input logic [15:0] p, input logic [1:0] m, input logic t);
    prescale    = p;
    parity_mode = m;
    two_stop    = t;
  endtask

  task automatic push_word(input logic [7:0] d);
    int     waits;
    frame_t f;
    waits         = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && waits < 20000) begin
      @(negedge clk);
      waits++;
    end
    if (!s_axis_tready) begin
      check("tready_wait_timeout", s_axis_tready, 1'b1);
      s_axis_tvalid = 1'b0;
      return;
    end
    f.data   = d;
    f.mode   = parity_mode;
    f.two    = two_stop;
    f.period = 8 * ((prescale == 16'd0) ? 1 : int'(prescale));
    sb_q.push_back(f);
    exp_done++;
    @(posedge clk);
    @(negedge clk);
    last_acc_cyc  = cyc;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_low"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    check({tag, "_all_frames_sent"}, sb_q.size(), 0);
  endtask

  task automatic wait_starts(input int n);
    int k;
    k = 0;
    while (starts.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", (starts.size() >= n), 1'b1);
  endtask

  initial begin
    int d0;
    int acc[6];
    logic [7:0] words[6];
    int waits;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_tready", s_axis_tready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_fifo_level", fifo_level, 0);
    check("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame on an idle line.
    set_cfg(16'd1, 2'b00, 1'b0);
    starts.delete();
    d0 = n_done_seen;
    push_word(8'hA5);
    wait_idle("a5");
    check("a5_frames_started", starts.size(), 1);
    if (starts.size() > 0) check("a5_start_latency", starts[0] - last_acc_cyc, 1);
    check("a5_done_pulses", n_done_seen - d0, 1);

    // Even parity, two back-to-back 0x07 frames of 176 clocks; then odd parity.
    set_cfg(16'd2, 2'b01, 1'b0);
    starts.delete();
    push_word(8'h07);
    push_word(8'h07);
    wait_idle("even");
    if (starts.size() == 2) check("even_frame_period", starts[1] - starts[0], 176);
    else check("even_frames_started", starts.size(), 2);
    set_cfg(16'd2, 2'b10, 1'b0);
    push_word(8'h07);
    wait_idle("odd");

    // Two stop bits, two words pushed together.
    set_cfg(16'd1, 2'b00, 1'b1);
    starts.delete();
    push_word(8'h3C);
    push_word(8'hC3);
    wait_idle("two_stop");
    if (starts.size() == 2) check("two_stop_start_gap", starts[1] - starts[0], 88);
    else check("two_stop_frames_started", starts.size(), 2);

    // Back-pressure: six words streamed at prescale 100.
    set_cfg(16'd100, 2'b00, 1'b0);
    starts.delete();
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("bp_level_full", fifo_level, 4);
        check("bp_tready_low", s_axis_tready, 1'b0);
        s_axis_tdata  = words[i];
        s_axis_tvalid = 1'b1;
        waits = 0;
        while (!s_axis_tready && waits < 20000) begin
          @(negedge clk);
          waits++;
        end
        check("bp_tready_rises_with_frame_done", frame_done, 1'b1);
        check("bp_level_after_pop", fifo_level, 3);
      end
      push_word(words[i]);
      acc[i] = last_acc_cyc;
    end
    check("bp_first_five_consecutive", acc[4] - acc[0], 4);
    wait_idle("bp");
    check("bp_frames_started", starts.size(), 6);

    // Mid-frame configuration change.
    set_cfg(16'd2, 2'b01, 1'b0);
    starts.delete();
    push_word(8'h5A);
    wait_starts(1);
    repeat (56) @(negedge clk);
    set_cfg(16'd2, 2'b10, 1'b1);
    push_word(8'h96);
    wait_idle("cfg_change");
    if (starts.size() == 2) check("cfg_change_first_frame_len", starts[1] - starts[0], 176);
    else check("cfg_change_frames_started", starts.size(), 2);

    // Reset while a frame is in the data phase, with another word queued.
    set_cfg(16'd4, 2'b00, 1'b0);
    starts.delete();
    push_word(8'hF0);
    push_word(8'h0F);
    wait_starts(1);
    repeat (96) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_txd", txd, 1'b1);
    check("midreset_tready", s_axis_tready, 1'b1);
    check("midreset_fifo_level", fifo_level, 0);
    check("midreset_busy", busy, 1'b0);
    sb_q.delete();
    exp_done -= 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_line_idle", txd, 1'b1);
    starts.delete();
    push_word(8'h3C);
    wait_idle("postreset");
    check("postreset_frames_started", starts.size(), 1);

    // Randomised bursts; configuration changes only while idle.
    for (int b = 0; b < 8; b++) begin
      if (b == 0) set_cfg(16'd0, 2'b11, 1'b0);
      else set_cfg(16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        push_word(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rand");
    end

    check("frame_done_count", n_done_seen, exp_done);
    check("spurious_frame_done", spurious, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
